// File: rtl/vanilla_int_scoreboard.sv
// vanilla_int_scoreboard
//   Integer-register scoreboard for the ID stage. Tracks which x-registers have a
//   long-latency write in flight (loads, mul/div, AMO) and stalls the instruction in
//   ID on RAW/WAW hazards or when the outstanding-op budget is used up. Entries are
//   cleared by the writeback ports.
//
// Ports
//   clk_i, reset_n_i       clock, asynchronous active-low reset
//   id_v_i                 valid instruction in ID
//   id_rs1_i/rs2_i/rd_i    decoded register indices
//   op_reads_rf1_i/2_i     decoder source-operand usage
//   op_writes_rf_i         decoder destination usage (0 when rd == x0)
//   is_long_op_i           load | mul/div | amo
//   issue_i                ID instruction advances to EXE this cycle
//   clear_v_i/clear_id_i   per-port writeback clear (port p at [p*idx_w +: idx_w])
//   stall_o                hazard or credit stall
//   pending_o              scoreboard bits (bit 0 always 0)
//   outstanding_o          number of long ops in flight
//   clear_err_o            sticky protocol-error flag
module vanilla_int_scoreboard #(
    parameter int reg_els_p   = 32,
    parameter int num_clear_p = 2,
    parameter int max_out_p   = 16,
    localparam int idx_w      = $clog2(reg_els_p),
    localparam int cnt_w      = $clog2(max_out_p + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         id_v_i,
    input  logic [idx_w-1:0]             id_rs1_i,
    input  logic [idx_w-1:0]             id_rs2_i,
    input  logic [idx_w-1:0]             id_rd_i,
    input  logic                         op_reads_rf1_i,
    input  logic                         op_reads_rf2_i,
    input  logic                         op_writes_rf_i,
    input  logic                         is_long_op_i,
    input  logic                         issue_i,
    input  logic [num_clear_p-1:0]       clear_v_i,
    input  logic [idx_w*num_clear_p-1:0] clear_id_i,
    output logic                         stall_o,
    output logic [reg_els_p-1:0]         pending_o,
    output logic [cnt_w-1:0]             outstanding_o,
    output logic                         clear_err_o
);

    logic [reg_els_p-1:0] pending;
    logic [reg_els_p-1:0] pend_eff;
    logic [reg_els_p-1:0] set_mask;
    logic [reg_els_p-1:0] clr_mask;
    logic [cnt_w-1:0]     outstanding;
    logic [cnt_w-1:0]     n_clr;
    logic [idx_w-1:0]     cid;
    logic                 clear_err;
    logic                 raw, waw, cred;
    logic                 set_v;
    logic                 bad_clr;

    // Hazards look only at registered state; a clear landing this cycle does not
    // release the stall until the following cycle.
    always_comb begin
        pend_eff    = pending;
        pend_eff[0] = 1'b0;
        raw   = (op_reads_rf1_i & pend_eff[id_rs1_i]) | (op_reads_rf2_i & pend_eff[id_rs2_i]);
        waw   = op_writes_rf_i & pend_eff[id_rd_i];
        cred  = op_writes_rf_i & is_long_op_i & (outstanding == cnt_w'(max_out_p));
        stall_o = id_v_i & (raw | waw | cred);
        set_v = id_v_i & issue_i & ~stall_o & op_writes_rf_i & is_long_op_i
              & (id_rd_i != '0);
        set_mask = '0;
        if (set_v) set_mask[id_rd_i] = 1'b1;
    end

    // A clear is effective only for a pending, non-zero index not already cleared
    // by a lower-numbered port this cycle; everything else is a protocol error and
    // leaves both the bits and the counter alone, which keeps the counter equal to
    // popcount(pending).
    always_comb begin
        clr_mask = '0;
        n_clr    = '0;
        bad_clr  = 1'b0;
        cid      = '0;
        for (int p = 0; p < num_clear_p; p++) begin
            cid = clear_id_i[p*idx_w +: idx_w];
            if (clear_v_i[p]) begin
                if ((cid == '0) || !pending[cid] || clr_mask[cid]) begin
                    bad_clr = 1'b1;
                end else begin
                    clr_mask[cid] = 1'b1;
                    n_clr = n_clr + cnt_w'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pending     <= '0;
            outstanding <= '0;
            clear_err   <= 1'b0;
        end else begin
            // set applied after clear so a new op on a just-retired index keeps its bit
            pending     <= (pending & ~clr_mask) | set_mask;
            outstanding <= outstanding + {{(cnt_w-1){1'b0}}, set_v} - n_clr;
            clear_err   <= clear_err | bad_clr | (issue_i & stall_o);
        end
    end

    assign pending_o     = pending;
    assign outstanding_o = outstanding;
    assign clear_err_o   = clear_err;

endmodule

// File: tb/tb_vanilla_int_scoreboard.sv
module tb_vanilla_int_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_v = 1'b0;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic        r1 = 1'b0, r2 = 1'b0, w = 1'b0, lng = 1'b0, iss = 1'b0;
    logic [1:0]  clear_v = '0;
    logic [9:0]  clear_id = '0;
    logic        stall;
    logic [31:0] pending;
    logic [4:0]  outstanding;
    logic        clear_err;

    int total = 0;
    int bad = 0;

    vanilla_int_scoreboard dut (
        .clk_i          (clk),
        .reset_n_i      (rst_n),
        .id_v_i         (id_v),
        .id_rs1_i       (rs1),
        .id_rs2_i       (rs2),
        .id_rd_i        (rd),
        .op_reads_rf1_i (r1),
        .op_reads_rf2_i (r2),
        .op_writes_rf_i (w),
        .is_long_op_i   (lng),
        .issue_i        (iss),
        .clear_v_i      (clear_v),
        .clear_id_i     (clear_id),
        .stall_o        (stall),
        .pending_o      (pending),
        .outstanding_o  (outstanding),
        .clear_err_o    (clear_err)
    );

    always #5 clk = ~clk;

    task automatic drive_idle();
        id_v = 0; rs1 = 0; rs2 = 0; rd = 0; r1 = 0; r2 = 0; w = 0; lng = 0; iss = 0;
        clear_v = 0; clear_id = 0;
    endtask

    task automatic drive_id(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                            input logic ra, input logic rb, input logic wd,
                            input logic lo, input logic is);
        id_v = 1; rs1 = a; rs2 = b; rd = d; r1 = ra; r2 = rb; w = wd; lng = lo; iss = is;
    endtask

    task automatic test_reset();
        drive_idle();
        @(negedge clk); #1;
        total++; if (pending !== 32'h0) begin bad++; $display("FAIL reset_pending: got %h want 0", pending); end
        total++; if (outstanding !== 5'd0) begin bad++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
        total++; if (clear_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", clear_err); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall); end
        rst_n = 1;
    endtask

    task automatic test_raw();
        @(negedge clk); drive_id(5'd2, 5'd0, 5'd5, 1, 0, 1, 1, 1);   // lw x5
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL raw_lw_issue: got %b want 0", stall); end
        @(negedge clk); drive_id(5'd5, 5'd1, 5'd6, 1, 1, 1, 0, 0);   // add x6,x5,x1
        clear_v = 2'b01; clear_id = {5'd0, 5'd5};
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL raw_stall: got %b want 1", stall); end
        total++; if (pending !== 32'h0000_0020) begin bad++; $display("FAIL raw_pending: got %h want 00000020", pending); end
        total++; if (outstanding !== 5'd1) begin bad++; $display("FAIL raw_outstanding: got %0d want 1", outstanding); end
        @(negedge clk); clear_v = 0; clear_id = 0; #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL raw_release: got %b want 0", stall); end
        total++; if (outstanding !== 5'd0) begin bad++; $display("FAIL raw_cleared_cnt: got %0d want 0", outstanding); end
        iss = 1;
        @(negedge clk); drive_idle();
    endtask

    task automatic test_waw();
        @(negedge clk); drive_id(5'd1, 5'd2, 5'd7, 1, 1, 1, 1, 1);   // mul x7
        @(negedge clk); drive_id(5'd0, 5'd0, 5'd7, 0, 0, 1, 1, 0);   // long op writing x7
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL waw_stall: got %b want 1", stall); end
        drive_id(5'd0, 5'd0, 5'd8, 0, 0, 1, 0, 0);                   // ALU op writing x8
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL waw_alu_x8: got %b want 0", stall); end
        @(negedge clk); drive_idle(); clear_v = 2'b10; clear_id = {5'd7, 5'd0};
        @(negedge clk); drive_idle(); #1;
        total++; if (pending !== 32'h0) begin bad++; $display("FAIL waw_clear_p1: got %h want 0", pending); end
    endtask

    task automatic test_credit();
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk); drive_id(5'd0, 5'd0, 5'(i), 0, 0, 1, 1, 1);
            #1;
            total++; if (stall !== 1'b0) begin bad++; $display("FAIL credit_fill_%0d: got %b want 0", i, stall); end
        end
        @(negedge clk); drive_id(5'd0, 5'd0, 5'd17, 0, 0, 1, 1, 0);
        #1;
        total++; if (outstanding !== 5'd16) begin bad++; $display("FAIL credit_full_cnt: got %0d want 16", outstanding); end
        total++; if (pending !== 32'h0001_FFFE) begin bad++; $display("FAIL credit_full_pend: got %h want 0001fffe", pending); end
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL credit_stall: got %b want 1", stall); end
        drive_id(5'd0, 5'd0, 5'd20, 0, 0, 1, 0, 0);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL credit_short_op: got %b want 0", stall); end
        drive_id(5'd0, 5'd0, 5'd17, 0, 0, 1, 1, 0);
        clear_v = 2'b01; clear_id = {5'd0, 5'd3};
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL credit_no_bypass: got %b want 1", stall); end
        @(negedge clk); clear_v = 0; clear_id = 0; iss = 1;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL credit_release: got %b want 0", stall); end
        total++; if (outstanding !== 5'd15) begin bad++; $display("FAIL credit_after_clr: got %0d want 15", outstanding); end
        @(negedge clk); drive_idle(); #1;
        total++; if (outstanding !== 5'd16) begin bad++; $display("FAIL credit_refill: got %0d want 16", outstanding); end
        total++; if (pending !== 32'h0003_FFF6) begin bad++; $display("FAIL credit_refill_pend: got %h want 0003fff6", pending); end
        for (int i = 1; i <= 17; i++) begin
            if (i != 3) begin
                clear_v = 2'b01; clear_id = {5'd0, 5'(i)};
                @(negedge clk);
            end
        end
        drive_idle(); #1;
        total++; if (outstanding !== 5'd0) begin bad++; $display("FAIL credit_drain_cnt: got %0d want 0", outstanding); end
        total++; if (pending !== 32'h0) begin bad++; $display("FAIL credit_drain_pend: got %h want 0", pending); end
        total++; if (clear_err !== 1'b0) begin bad++; $display("FAIL credit_no_err: got %b want 0", clear_err); end
    endtask

    task automatic test_set_clear();
        @(negedge clk); drive_id(5'd0, 5'd0, 5'd9, 0, 0, 1, 1, 1);   // lw x9 (old op)
        @(negedge clk); drive_id(5'd0, 5'd0, 5'd9, 0, 0, 1, 1, 0);   // new lw x9 waits
        clear_v = 2'b01; clear_id = {5'd0, 5'd9};
        #1;
        total++; if (outstanding !== 5'd1) begin bad++; $display("FAIL sc_old_cnt: got %0d want 1", outstanding); end
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL sc_waw: got %b want 1", stall); end
        @(negedge clk); clear_v = 0; clear_id = 0; iss = 1;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL sc_release: got %b want 0", stall); end
        @(negedge clk); drive_idle(); #1;
        total++; if (pending !== 32'h0000_0200) begin bad++; $display("FAIL sc_pending9: got %h want 00000200", pending); end
        total++; if (outstanding !== 5'd1) begin bad++; $display("FAIL sc_cnt_same: got %0d want 1", outstanding); end
        clear_v = 2'b10; clear_id = {5'd9, 5'd0};
        @(negedge clk); drive_idle(); #1;
        total++; if (pending !== 32'h0) begin bad++; $display("FAIL sc_final: got %h want 0", pending); end
    endtask

    task automatic test_bad_clear();
        @(negedge clk); clear_v = 2'b11; clear_id = {5'd0, 5'd12};
        #1;
        total++; if (clear_err !== 1'b0) begin bad++; $display("FAIL bad_err_early: got %b want 0", clear_err); end
        @(negedge clk); drive_idle(); #1;
        total++; if (clear_err !== 1'b1) begin bad++; $display("FAIL bad_err_set: got %b want 1", clear_err); end
        total++; if (pending !== 32'h0) begin bad++; $display("FAIL bad_pending: got %h want 0", pending); end
        total++; if (outstanding !== 5'd0) begin bad++; $display("FAIL bad_cnt: got %0d want 0", outstanding); end
        drive_id(5'd0, 5'd0, 5'd10, 0, 0, 1, 1, 1);
        @(negedge clk); drive_id(5'd0, 5'd0, 5'd11, 0, 0, 1, 1, 1);
        @(negedge clk); drive_idle(); clear_v = 2'b11; clear_id = {5'd10, 5'd10};
        @(negedge clk); drive_idle(); #1;
        total++; if (pending !== 32'h0000_0800) begin bad++; $display("FAIL dup_pending: got %h want 00000800", pending); end
        total++; if (outstanding !== 5'd1) begin bad++; $display("FAIL dup_cnt: got %0d want 1", outstanding); end
        clear_v = 2'b10; clear_id = {5'd11, 5'd0};
        @(negedge clk); drive_idle();
        @(negedge clk); @(negedge clk); #1;
        total++; if (outstanding !== 5'd0) begin bad++; $display("FAIL dup_drain: got %0d want 0", outstanding); end
        total++; if (clear_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", clear_err); end
    endtask

    task automatic test_async_reset();
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk); drive_id(5'd0, 5'd0, 5'(i), 0, 0, 1, 1, 1);
        end
        @(negedge clk); drive_idle(); #1;
        total++; if (outstanding !== 5'd5) begin bad++; $display("FAIL ar_before: got %0d want 5", outstanding); end
        #1 rst_n = 0;
        #1;
        total++; if (pending !== 32'h0) begin bad++; $display("FAIL ar_pending: got %h want 0", pending); end
        total++; if (outstanding !== 5'd0) begin bad++; $display("FAIL ar_cnt: got %0d want 0", outstanding); end
        total++; if (clear_err !== 1'b0) begin bad++; $display("FAIL ar_err: got %b want 0", clear_err); end
        @(negedge clk); rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_raw();
        test_waw();
        test_credit();
        test_set_clear();
        test_bad_clear();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
